// File: rtl/score_keeper.sv
// Pong game controller: edge-detects score pulses and START/RESTART keys, keeps both scores, holds the ball.
// Latency: scores, winner and state update on the first edge that samples an event; status outputs decode state.
// Backpressure: none; inputs are level signals and a held input is counted once.
module score_keeper #(
    parameter int START        = 103,
    parameter int RESTART      = 98,
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 25000000
) (
    input  logic       i_CLK,
    input  logic       i_RST_N,
    input  logic [7:0] i_key_byte,
    input  logic       i_p1_scored,
    input  logic       i_p2_scored,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic       o_ball_hold,
    output logic       o_game_active,
    output logic       o_game_over,
    output logic [1:0] o_winner
);

    localparam int            CW       = $clog2(PAUSE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PAUSE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAME_OVER} state_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [3:0]    p1_nxt, p2_nxt;
    logic [1:0]    winner_nxt;
    logic          p1_q, p2_q, start_q, restart_q;
    logic          start_hit, restart_hit;
    logic          start_ev, restart_ev, p1_ev, p2_ev;
    logic [3:0]    p1_inc, p2_inc;

    assign start_hit   = (i_key_byte == 8'(START));
    assign restart_hit = (i_key_byte == 8'(RESTART));
    assign start_ev    = start_hit & ~start_q;
    assign restart_ev  = restart_hit & ~restart_q;
    assign p1_ev       = i_p1_scored & ~p1_q;
    assign p2_ev       = i_p2_scored & ~p2_q;
    assign p1_inc      = o_p1_score + 4'd1;
    assign p2_inc      = o_p2_score + 4'd1;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            o_p1_score <= 4'd0;
            o_p2_score <= 4'd0;
            o_winner   <= 2'b00;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            start_q    <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            cnt_q      <= cnt_nxt;
            o_p1_score <= p1_nxt;
            o_p2_score <= p2_nxt;
            o_winner   <= winner_nxt;
            p1_q       <= i_p1_scored;
            p2_q       <= i_p2_scored;
            start_q    <= start_hit;
            restart_q  <= restart_hit;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        p1_nxt     = o_p1_score;
        p2_nxt     = o_p2_score;
        winner_nxt = o_winner;
        if (restart_ev) begin
            state_nxt  = IDLE;
            p1_nxt     = 4'd0;
            p2_nxt     = 4'd0;
            winner_nxt = 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ev) begin
                        state_nxt = SERVE;
                        p1_nxt    = 4'd0;
                        p2_nxt    = 4'd0;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                SERVE: begin
                    if (cnt_q == '0) state_nxt = PLAY;
                    else             cnt_nxt   = cnt_q - CNT_ONE;
                end
                PLAY: begin
                    // A simultaneous p2 point is dropped in favour of p1.
                    if (p1_ev) begin
                        p1_nxt = p1_inc;
                        if (p1_inc == WIN) begin
                            state_nxt  = GAME_OVER;
                            winner_nxt = 2'b01;
                        end else begin
                            state_nxt = SERVE;
                            cnt_nxt   = CNT_LOAD;
                        end
                    end else if (p2_ev) begin
                        p2_nxt = p2_inc;
                        if (p2_inc == WIN) begin
                            state_nxt  = GAME_OVER;
                            winner_nxt = 2'b10;
                        end else begin
                            state_nxt = SERVE;
                            cnt_nxt   = CNT_LOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ball_hold   = (state_q != PLAY);
    assign o_game_active = (state_q == SERVE) || (state_q == PLAY);
    assign o_game_over   = (state_q == GAME_OVER);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper with a behavioural game model (WIN_SCORE=3, PAUSE_CYCLES=4).
module tb_score_keeper;

    localparam int W = 3;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] key_byte = 8'd0;
    logic       p1_sc = 1'b0;
    logic       p2_sc = 1'b0;
    logic [3:0] p1_score, p2_score;
    logic       ball_hold, game_active, game_over;
    logic [1:0] winner;

    score_keeper #(.START(103), .RESTART(98), .WIN_SCORE(W), .PAUSE_CYCLES(P)) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_key_byte(key_byte),
        .i_p1_scored(p1_sc), .i_p2_scored(p2_sc),
        .o_p1_score(p1_score), .o_p2_score(p2_score), .o_ball_hold(ball_hold),
        .o_game_active(game_active), .o_game_over(game_over), .o_winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] v;
        int          ph;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: game mode as text-level ints, serve measured in remaining hold cycles.
    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_OVER = 3;
    int m_mode, m_s1, m_s2, m_win, m_left;
    bit pv1, pv2, pvs, pvr;

    function automatic logic [12:0] pack_out(int s1, int s2, bit hold, bit act, bit over, int win);
        return {4'(s1), 4'(s2), hold, act, over, 2'(win)};
    endfunction

    function automatic logic [12:0] model_vec();
        return pack_out(m_s1, m_s2, m_mode != M_PLAY,
                        m_mode == M_SERVE || m_mode == M_PLAY, m_mode == M_OVER, m_win);
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0;
        pv1 = 0; pv2 = 0; pvs = 0; pvr = 0;
    endtask

    task automatic point(inout int s, input int who);
        s = s + 1;
        if (s == W) begin
            m_mode = M_OVER;
            m_win  = who;
        end else begin
            m_mode = M_SERVE;
            m_left = P;
        end
    endtask

    task automatic model_step(input logic [7:0] key, input bit a, input bit b);
        bit ks, kr, e1, e2;
        ks = (key == 8'd103) && !pvs;
        kr = (key == 8'd98) && !pvr;
        e1 = a && !pv1;
        e2 = b && !pv2;
        if (kr) begin
            m_mode = M_IDLE; m_s1 = 0; m_s2 = 0; m_win = 0;
        end else if (m_mode == M_IDLE) begin
            if (ks) begin
                m_mode = M_SERVE; m_s1 = 0; m_s2 = 0; m_left = P;
            end
        end else if (m_mode == M_SERVE) begin
            m_left = m_left - 1;
            if (m_left == 0) m_mode = M_PLAY;
        end else if (m_mode == M_PLAY) begin
            if (e1)      point(m_s1, 1);
            else if (e2) point(m_s2, 2);
        end
        pvs = (key == 8'd103);
        pvr = (key == 8'd98);
        pv1 = a;
        pv2 = b;
    endtask

    function automatic logic [12:0] dut_vec();
        return {p1_score, p2_score, ball_hold, game_active, game_over, winner};
    endfunction

    task automatic report(input string name, input int ph, input logic [12:0] act, input logic [12:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s phase=%0d got p1=%0d p2=%0d hold=%b act=%b over=%b win=%b required p1=%0d p2=%0d hold=%b act=%b over=%b win=%b",
                     name, ph, act[12:9], act[8:5], act[4], act[3], act[2], act[1:0],
                     req[12:9], req[8:5], req[4], req[3], req[2], req[1:0]);
        end
    endtask

    // Monitor: one expected entry per rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            report("cycle", e.ph, dut_vec(), e.v);
        end
    end

    task automatic step(input logic rst, input logic [7:0] key, input logic a, input logic b, input int ph);
        exp_t e;
        @(negedge clk);
        rst_n = rst; key_byte = key; p1_sc = a; p2_sc = b;
        if (!rst) model_reset();
        else      model_step(key, a, b);
        e.v  = model_vec();
        e.ph = ph;
        q.push_back(e);
        if (!rst) begin
            #1;
            report("async_reset", ph, dut_vec(), pack_out(0, 0, 1, 0, 0, 0));
        end
    endtask

    task automatic idle(input int n, input int ph);
        for (int i = 0; i < n; i++) step(1, 8'd0, 0, 0, ph);
    endtask

    task automatic start_game(input int ph);
        for (int i = 0; i < 2; i++) step(1, 8'd103, 0, 0, ph);
        idle(P + 1, ph);
    endtask

    initial begin
        logic [7:0] k;
        bit a, b, r;
        model_reset();
        for (int i = 0; i < 3; i++) step(0, 8'd0, 0, 0, 0);
        idle(2, 0);

        // 1: held START gives one start, 4-cycle serve
        for (int i = 0; i < 10; i++) step(1, 8'd103, 0, 0, 1);
        idle(4, 1);
        #2 report("t1_play", 1, dut_vec(), pack_out(0, 0, 0, 1, 0, 0));

        // 2: held p1 pulse counted once
        for (int i = 0; i < 3; i++) step(1, 8'd0, 1, 0, 2);
        idle(6, 2);

        // 3: simultaneous points, p1 wins the tie
        step(1, 8'd0, 1, 1, 3);
        idle(6, 3);
        #2 report("t3_scores", 3, dut_vec(), pack_out(2, 0, 0, 1, 0, 0));

        // 5: RESTART during serve at 2/1
        step(1, 8'd0, 0, 1, 5);
        idle(2, 5);
        step(1, 8'd98, 0, 0, 5);
        step(1, 8'd98, 0, 0, 5);
        idle(2, 5);
        #2 report("t5_idle", 5, dut_vec(), pack_out(0, 0, 1, 0, 0, 0));

        // 4: p2 wins, then everything but RESTART is ignored
        start_game(4);
        for (int n = 0; n < 3; n++) begin
            step(1, 8'd0, 0, 1, 4);
            idle(6, 4);
        end
        step(1, 8'd0, 1, 0, 4);
        step(1, 8'd0, 0, 1, 4);
        step(1, 8'd103, 0, 0, 4);
        idle(6, 4);
        #2 report("t4_over", 4, dut_vec(), pack_out(0, 3, 1, 0, 1, 2));
        step(1, 8'd98, 0, 0, 4);
        idle(2, 4);

        // 6: reset mid-play with p1 held high
        start_game(6);
        step(1, 8'd0, 0, 0, 6);
        step(1, 8'd0, 1, 0, 6);
        idle(6, 6);
        step(1, 8'd0, 1, 0, 6);
        step(0, 8'd0, 1, 0, 6);
        step(0, 8'd0, 1, 0, 6);
        for (int i = 0; i < 3; i++) step(1, 8'd0, 1, 0, 6);
        idle(2, 6);
        #2 report("t6_after_reset", 6, dut_vec(), pack_out(0, 0, 1, 0, 0, 0));

        // 7: randomized play
        k = 8'd0; a = 0; b = 0;
        for (int i = 0; i < 1500; i++) begin
            int rr;
            rr = int'($urandom_range(0, 99));
            if (rr < 6)       k = 8'd103;
            else if (rr < 8)  k = 8'd98;
            else if (rr < 20) k = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) a = !a;
            if ($urandom_range(0, 4) == 0) b = !b;
            r = ($urandom_range(0, 299) != 0);
            step(r, k, a, b, 7);
        end
        idle(3, 8);

        @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
